// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant codes
// and the fixed-priority pick used when both ports are eligible.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_STARTUP = 2'd0,
    ARB_IDLE    = 2'd1,
    ARB_IF      = 2'd2,
    ARB_DM      = 2'd3
  } MEM_ARB_states;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } MEM_ARB_grant;

  // Data port always wins a simultaneous request; IF gets the following slot.
  function automatic MEM_ARB_grant arb_pick(input logic if_elig, input logic dm_elig);
    MEM_ARB_grant g;
    if (dm_elig) begin
      g = GNT_DM;
    end else if (if_elig) begin
      g = GNT_IF;
    end else begin
      g = GNT_NONE;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM
// stage: power-up window, one access in flight, stall requests to hazard unit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int STARTUP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ready
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int SU_W  = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(MEM_LAT);
  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_CYC - 1);

  MEM_ARB_states     state_q, state_d;
  MEM_ARB_grant      gnt_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SU_W-1:0]   su_cnt_q, su_cnt_d;
  logic              ready_q, ready_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              dm_store_q, dm_store_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;

  // Next-state logic: startup count, arbitration, access sequencing and capture.
  always_comb begin
    state_d     = state_q;
    gnt_s       = GNT_NONE;
    cnt_d       = cnt_q;
    su_cnt_d    = su_cnt_q;
    ready_d     = ready_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dm_store_d  = dm_store_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;

    case (state_q)
      ARB_STARTUP: begin
        if (su_cnt_q == SU_LAST) begin
          state_d  = ARB_IDLE;
          ready_d  = 1'b1;
          su_cnt_d = '0;
        end else begin
          su_cnt_d = su_cnt_q + SU_W'(1);
        end
      end
      ARB_IDLE: begin
        // A port whose valid is pulsing this cycle is finishing, not asking again.
        gnt_s = arb_pick(if_req & ~if_valid_q, dm_req & ~dm_valid_q);
      end
      ARB_IF: begin
        if (cnt_q == CNT_DONE) begin
          cnt_d      = '0;
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
          state_d    = ARB_IDLE;
          gnt_s      = dm_req ? GNT_DM : GNT_NONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_DM: begin
        if (cnt_q == CNT_DONE) begin
          cnt_d      = '0;
          dm_valid_d = 1'b1;
          state_d    = ARB_IDLE;
          gnt_s      = if_req ? GNT_IF : GNT_NONE;
          if (!dm_store_q) begin
            dm_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARB_STARTUP;
        ready_d = 1'b0;
      end
    endcase

    // Grant handling is shared by IDLE and the completion-cycle handover.
    case (gnt_s)
      GNT_IF: begin
        state_d     = ARB_IF;
        cnt_d       = '0;
        mem_cs_d    = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
      GNT_DM: begin
        state_d     = ARB_DM;
        cnt_d       = '0;
        mem_cs_d    = 1'b1;
        mem_we_d    = dm_we;
        mem_addr_d  = dm_addr;
        mem_wdata_d = dm_wdata;
        dm_store_d  = dm_we;
      end
      default: begin
        mem_cs_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_STARTUP;
      cnt_q       <= '0;
      su_cnt_q    <= '0;
      ready_q     <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dm_store_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      su_cnt_q    <= su_cnt_d;
      ready_q     <= ready_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dm_store_q  <= dm_store_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ready     = ready_q;

  // Stalls must react to the request in the same cycle, but read 0 while in reset.
  assign stall_if  = rst_n & ((if_req & ~if_valid_q) | (if_req & ~ready_q));
  assign stall_mem = rst_n & ((dm_req & ~dm_valid_q) | (dm_req & ~ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARTUP_CYC=4): a per-cycle
// vector table plus hand sequences for startup, reset abort and streaming.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        ready;

  int total;
  int bad;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARTUP_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [31:0] mr;
    logic        cs;
    logic        we;
    logic [31:0] ma;
    logic [31:0] md;
    logic        chk_md;
    logic        iv;
    logic [31:0] ird;
    logic        dv;
    logic [31:0] drd;
    logic        sif;
    logic        smem;
  } vec_t;

  vec_t tv[19];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr,
    input logic cs, input logic we, input logic [31:0] ma, input logic [31:0] md,
    input logic chk_md, input logic iv, input logic [31:0] ird,
    input logic dv, input logic [31:0] drd, input logic sif, input logic smem);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
    v.cs = cs; v.we = we; v.ma = ma; v.md = md; v.chk_md = chk_md;
    v.iv = iv; v.ird = ird; v.dv = dv; v.drd = drd; v.sif = sif; v.smem = smem;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Startup window from the release cycle onwards; ends at cycle 0 (first ready=1).
  task automatic startup_seq(input string tag, input logic exp_stall);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_ready%0d", tag, k), {31'd0, ready}, 32'd0);
      chk($sformatf("%s_stall%0d", tag, k), {31'd0, stall_if}, {31'd0, exp_stall});
      chk($sformatf("%s_cs%0d", tag, k), {31'd0, mem_cs}, 32'd0);
      chk($sformatf("%s_ivalid%0d", tag, k), {31'd0, if_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk($sformatf("%s_ready_up", tag), {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] DB;
    logic [31:0] CF;
    logic [31:0] BC;
    logic [31:0] exp_ma;
    logic        exp_cs;
    int          last_cs;

    total = 0;
    bad   = 0;
    DB = 32'hDEAD_BEEF;
    CF = 32'hCAFE_F00D;
    BC = 32'h0BAD_C0DE;

    //          ir    ia           dr    dw    da           dd            mr              cs    we    ma           md            chkmd iv    ird  dv    drd  sif   smem
    tv[0]  = mk(1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tv[1]  = mk(1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b1, 1'b0, 32'h100,  32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tv[2]  = mk(1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tv[3]  = mk(1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0,        DB,            1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    tv[4]  = mk(1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b1, DB,    1'b0, 32'h0, 1'b0, 1'b0);
    tv[5]  = mk(1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, DB,    1'b0, 32'h0, 1'b1, 1'b1);
    tv[6]  = mk(1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 32'h0,        32'h0,         1'b1, 1'b0, 32'h2000, 32'h0,        1'b0, 1'b0, DB,    1'b0, 32'h0, 1'b1, 1'b1);
    tv[7]  = mk(1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, DB,    1'b0, 32'h0, 1'b1, 1'b1);
    tv[8]  = mk(1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 32'h0,        CF,            1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, DB,    1'b0, 32'h0, 1'b1, 1'b1);
    tv[9]  = mk(1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 32'h0,        32'h0,         1'b1, 1'b0, 32'h104,  32'h0,        1'b0, 1'b0, DB,    1'b1, CF,    1'b1, 1'b0);
    tv[10] = mk(1'b1, 32'h104,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, DB,    1'b0, CF,    1'b1, 1'b0);
    tv[11] = mk(1'b1, 32'h104,  1'b0, 1'b0, 32'h0,    32'h0,        BC,            1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, DB,    1'b0, CF,    1'b1, 1'b0);
    tv[12] = mk(1'b1, 32'h104,  1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b1, BC,    1'b0, CF,    1'b0, 1'b0);
    tv[13] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, BC,    1'b0, CF,    1'b0, 1'b1);
    tv[14] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'h1234_5678, 32'h0,        1'b1, 1'b1, 32'h2004, 32'h1234_5678, 1'b1, 1'b0, BC,    1'b0, CF,    1'b0, 1'b1);
    tv[15] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, BC,    1'b0, CF,    1'b0, 1'b1);
    tv[16] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, BC,    1'b0, CF,    1'b0, 1'b1);
    tv[17] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h2004, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, BC,    1'b1, CF,    1'b0, 1'b0);
    tv[18] = mk(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0,        32'h0,         1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, BC,    1'b0, CF,    1'b0, 1'b0);

    // Reset with a fetch already requested: everything reads zero.
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
    chk("rst_ready",    {31'd0, ready}, 32'd0);
    chk("rst_cs",       {31'd0, mem_cs}, 32'd0);
    chk("rst_ivalid",   {31'd0, if_valid}, 32'd0);
    chk("rst_dvalid",   {31'd0, dm_valid}, 32'd0);
    chk("rst_irdata",   if_rdata, 32'd0);
    chk("rst_maddr",    mem_addr, 32'd0);
    rst_n = 1'b1;
    #1;
    startup_seq("su", 1'b1);

    // Fetch, contended load/fetch and store, one table row per cycle.
    for (int i = 0; i < 19; i++) begin
      if_req = tv[i].ir; if_addr = tv[i].ia;
      dm_req = tv[i].dr; dm_we = tv[i].dw; dm_addr = tv[i].da; dm_wdata = tv[i].dd;
      mem_rdata = tv[i].mr;
      #1;
      chk($sformatf("tv%0d_cs", i), {31'd0, mem_cs}, {31'd0, tv[i].cs});
      if (tv[i].cs) begin
        chk($sformatf("tv%0d_we", i), {31'd0, mem_we}, {31'd0, tv[i].we});
        chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].ma);
      end
      if (tv[i].chk_md) chk($sformatf("tv%0d_wdata", i), mem_wdata, tv[i].md);
      chk($sformatf("tv%0d_ivalid", i), {31'd0, if_valid}, {31'd0, tv[i].iv});
      chk($sformatf("tv%0d_irdata", i), if_rdata, tv[i].ird);
      chk($sformatf("tv%0d_dvalid", i), {31'd0, dm_valid}, {31'd0, tv[i].dv});
      chk($sformatf("tv%0d_drdata", i), dm_rdata, tv[i].drd);
      chk($sformatf("tv%0d_stall_if", i), {31'd0, stall_if}, {31'd0, tv[i].sif});
      chk($sformatf("tv%0d_stall_mem", i), {31'd0, stall_mem}, {31'd0, tv[i].smem});
      chk($sformatf("tv%0d_ready", i), {31'd0, ready}, 32'd1);
      @(posedge clk); #1;
    end

    // Reset abort while a fetch is at cnt=1.
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    chk("ab_cs", {31'd0, mem_cs}, 32'd1);
    chk("ab_addr", mem_addr, 32'h200);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("ab_cs0",     {31'd0, mem_cs}, 32'd0);
    chk("ab_ready0",  {31'd0, ready}, 32'd0);
    chk("ab_stall0",  {31'd0, stall_if}, 32'd0);
    chk("ab_irdata0", if_rdata, 32'd0);
    chk("ab_drdata0", dm_rdata, 32'd0);
    chk("ab_maddr0",  mem_addr, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
    rst_n  = 1'b1;
    #1;
    startup_seq("ab", 1'b0);

    // Streaming fetch with a load slotted in at the next IF completion.
    if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0;
    last_cs = -100;
    for (int c = 0; c < 17; c++) begin
      exp_cs = (c == 1) || (c == 4) || (c == 7) || (c == 12);
      case (c)
        1:       exp_ma = 32'h300;
        4:       exp_ma = 32'h3000;
        7:       exp_ma = 32'h304;
        12:      exp_ma = 32'h308;
        default: exp_ma = 32'h0;
      endcase
      chk($sformatf("st%0d_cs", c), {31'd0, mem_cs}, {31'd0, exp_cs});
      if (exp_cs) chk($sformatf("st%0d_addr", c), mem_addr, exp_ma);
      if (mem_cs) begin
        chk($sformatf("st%0d_gap_ok", c), {31'd0, (c - last_cs) >= 3}, 32'd1);
        last_cs   = c;
        mem_rdata = mem_addr ^ KEY;
      end
      chk($sformatf("st%0d_ivalid", c), {31'd0, if_valid},
          {31'd0, (c == 4) || (c == 10) || (c == 15)});
      chk($sformatf("st%0d_dvalid", c), {31'd0, dm_valid}, {31'd0, c == 7});
      if (if_valid) begin
        chk($sformatf("st%0d_irdata", c), if_rdata, if_addr ^ KEY);
        if_addr = if_addr + 32'd4;
      end
      if (dm_valid) begin
        chk($sformatf("st%0d_drdata", c), dm_rdata, 32'h3000 ^ KEY);
        dm_req = 1'b0;
      end
      if (c == 2) begin
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
